// File: rtl/pulse_sequencer.sv
// Replays a timed Ramsey/Rabi pulse cycle from a shadowed 8-entry duration table.
// Define TAU_SWEEP_EN to add a per-cycle linear sweep of the TAU segment.
module pulse_sequencer #(
   parameter int unsigned PRESC = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        isrun,
   input  logic        isramsey,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic        laser,
   output logic        mw,
   output logic        gate,
   output logic        sync,
   output logic        busy,
`ifdef TAU_SWEEP_EN
   input  logic [15:0] sweep_step,
   input  logic [7:0]  sweep_len,
   output logic [7:0]  sweep_idx,
`endif
   output logic        cycle_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_GAP, S_PI2A, S_TAU,
      S_PI2B, S_MW, S_READ, S_REP
   } state_t;

   localparam logic [15:0] PMAX = 16'(PRESC - 1);

   state_t      state_q, state_d;
   logic [15:0] shadow_q [8];
   logic [15:0] shadow_d [8];
   logic [15:0] active_q [8];
   logic [15:0] active_d [8];
   logic [15:0] presc_q, presc_d;
   logic [15:0] unit_q, unit_d;
   logic        ramsey_q, ramsey_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        laser_q, laser_d;
   logic        mw_q, mw_d;
   logic        gate_q, gate_d;
   logic        sync_q, sync_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [15:0] tau_units;
   logic [15:0] seg_units;
   logic [15:0] read_units;
   logic [15:0] gate_units;
   logic        seg_end;
   logic        enter_init;

   function automatic logic [15:0] nz(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

`ifdef TAU_SWEEP_EN
   logic [7:0]  sweep_q, sweep_d;
   logic [15:0] sweep_off;

   always_comb begin
      sweep_off = sweep_step * {8'd0, sweep_q};
      tau_units = nz(active_q[3] + sweep_off);
      sweep_d   = sweep_q;
      if (state_d == S_IDLE) begin
         sweep_d = 8'd0;
      end else if (state_q == S_REP && seg_end) begin
         if (sweep_len == 8'd0 || sweep_q + 8'd1 >= sweep_len)
            sweep_d = 8'd0;
         else
            sweep_d = sweep_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sweep_q <= 8'd0;
      else        sweep_q <= sweep_d;
   end

   assign sweep_idx = sweep_q;
`else
   always_comb tau_units = nz(active_q[3]);
`endif

   always_comb begin
      read_units = nz(active_q[5]);
      gate_units = (active_q[6] < read_units) ? active_q[6] : read_units;
      unique case (state_q)
         S_INIT:  seg_units = nz(active_q[0]);
         S_GAP:   seg_units = nz(active_q[1]);
         S_PI2A:  seg_units = nz(active_q[2]);
         S_TAU:   seg_units = tau_units;
         S_PI2B:  seg_units = nz(active_q[2]);
         S_MW:    seg_units = nz(active_q[4]);
         S_READ:  seg_units = read_units;
         S_REP:   seg_units = nz(active_q[7]);
         default: seg_units = 16'd1;
      endcase
      seg_end = (presc_q == PMAX) && (unit_q == seg_units - 16'd1);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (isrun)   state_d = S_INIT;
         S_INIT: if (seg_end) state_d = S_GAP;
         S_GAP:  if (seg_end) state_d = ramsey_q ? S_PI2A : S_MW;
         S_PI2A: if (seg_end) state_d = S_TAU;
         S_TAU:  if (seg_end) state_d = S_PI2B;
         S_PI2B: if (seg_end) state_d = S_READ;
         S_MW:   if (seg_end) state_d = S_READ;
         S_READ: if (seg_end) state_d = S_REP;
         S_REP:  if (seg_end) state_d = isrun ? S_INIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      enter_init = (state_d == S_INIT) && (state_q != S_INIT);
      ramsey_d   = enter_init ? isramsey : ramsey_q;
      active_d   = enter_init ? shadow_q : active_q;

      shadow_d = shadow_q;
      if (cfg_we) shadow_d[cfg_addr] = cfg_data;
      rd_data_d = shadow_q[rd_addr];

      if (state_d != state_q || state_d == S_IDLE) begin
         presc_d = 16'd0;
         unit_d  = 16'd0;
      end else if (presc_q == PMAX) begin
         presc_d = 16'd0;
         unit_d  = unit_q + 16'd1;
      end else begin
         presc_d = presc_q + 16'd1;
         unit_d  = unit_q;
      end

      // Outputs are decoded from the next state so they flip with it.
      laser_d = (state_d == S_INIT) || (state_d == S_READ);
      mw_d    = (state_d == S_PI2A) || (state_d == S_PI2B) ||
                (state_d == S_MW);
      gate_d  = (state_d == S_READ) && (unit_d < gate_units);
      sync_d  = enter_init;
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_REP) && (presc_d == PMAX) &&
                (unit_d == nz(active_q[7]) - 16'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shadow_q  <= '{default: '0};
         active_q  <= '{default: '0};
         presc_q   <= 16'd0;
         unit_q    <= 16'd0;
         ramsey_q  <= 1'b0;
         rd_data_q <= 16'd0;
         laser_q   <= 1'b0;
         mw_q      <= 1'b0;
         gate_q    <= 1'b0;
         sync_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         presc_q   <= presc_d;
         unit_q    <= unit_d;
         ramsey_q  <= ramsey_d;
         rd_data_q <= rd_data_d;
         laser_q   <= laser_d;
         mw_q      <= mw_d;
         gate_q    <= gate_d;
         sync_q    <= sync_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign laser      = laser_q;
   assign mw         = mw_q;
   assign gate       = gate_q;
   assign sync       = sync_q;
   assign busy       = busy_q;
   assign cycle_done = done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a cycle-level reference model feeds
// run-length segments of the expected output stream to a checking monitor.
module tb_pulse_sequencer;

   localparam int P = 2;

   logic        clk = 1'b0;
   logic        rst_n, isrun, isramsey, cfg_we;
   logic [2:0]  cfg_addr, rd_addr;
   logic [15:0] cfg_data, rd_data;
   logic        laser, mw, gate, sync, busy, cycle_done;

   pulse_sequencer #(.PRESC(P)) dut (
      .clk(clk), .rst_n(rst_n), .isrun(isrun), .isramsey(isramsey),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .laser(laser), .mw(mw),
      .gate(gate), .sync(sync), .busy(busy), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic        run;
      logic        ram;
      logic        we;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [2:0]  rda;
   } plan_t;

   typedef struct {
      logic [21:0] v;
      int          len;
   } seg_t;

   localparam logic [5:0] LASER = 6'b100000;
   localparam logic [5:0] MWB   = 6'b010000;
   localparam logic [5:0] GATE  = 6'b001000;
   localparam logic [5:0] SYNC  = 6'b000100;
   localparam logic [5:0] BUSY  = 6'b000010;
   localparam logic [5:0] DONE  = 6'b000001;

   plan_t       plan[$];
   seg_t        exp_q[$];
   logic [5:0]  cyc_q[$];
   logic [15:0] m_shadow [8];
   logic [15:0] tbl [8];
   logic [2:0]  cur_rda;
   logic        cur_ram;
   int          checks = 0;
   int          passed = 0;

   // ---------------- plan construction ----------------
   task automatic put(input logic r, input logic run, input logic we,
                      input logic [2:0] a, input logic [15:0] d);
      plan_t p;
      p.rst_n = r; p.run = run; p.ram = cur_ram; p.we = we;
      p.addr = a; p.data = d; p.rda = cur_rda;
      plan.push_back(p);
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
   endtask

   task automatic hold(input int n);
      repeat (n) put(1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
   endtask

   task automatic rst(input int n);
      repeat (n) put(1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d,
                     input logic run);
      put(1'b1, run, 1'b1, a, d);
   endtask

   task automatic load_tbl();
      for (int i = 0; i < 8; i++) wr(3'(i), tbl[i], 1'b0);
   endtask

   // ---------------- reference model ----------------
   function automatic int ulen(input logic [15:0] d);
      return (d == 16'd0) ? 1 : int'({16'd0, d});
   endfunction

   task automatic add_seg(input logic [5:0] v, input int units);
      repeat (units * P) cyc_q.push_back(v | BUSY);
   endtask

   // One whole cycle, clock by clock, from a table snapshot and mode.
   task automatic build_cycle(input logic ram);
      logic [15:0] a [8];
      int rs, g;
      a = m_shadow;
      cyc_q.delete();
      add_seg(LASER, ulen(a[0]));
      add_seg(6'd0, ulen(a[1]));
      if (ram) begin
         add_seg(MWB, ulen(a[2]));
         add_seg(6'd0, ulen(a[3]));
         add_seg(MWB, ulen(a[2]));
      end else begin
         add_seg(MWB, ulen(a[4]));
      end
      rs = cyc_q.size();
      add_seg(LASER, ulen(a[5]));
      g = int'({16'd0, a[6]});
      if (g > ulen(a[5])) g = ulen(a[5]);
      for (int i = 0; i < g * P; i++) cyc_q[rs + i] = cyc_q[rs + i] | GATE;
      add_seg(6'd0, ulen(a[7]));
      cyc_q[0] = cyc_q[0] | SYNC;
      cyc_q[cyc_q.size() - 1] = cyc_q[cyc_q.size() - 1] | DONE;
   endtask

   task automatic run_model();
      logic [21:0] cv;
      int          elen;
      elen = 0;
      cv = '0;
      for (int i = 0; i < 8; i++) m_shadow[i] = 16'd0;
      for (int n = 0; n < plan.size(); n++) begin
         plan_t       p;
         logic [5:0]  o;
         logic [15:0] rd;
         logic [21:0] ev;
         p = plan[n];
         if (!p.rst_n) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = 16'd0;
            cyc_q.delete();
            o = 6'd0;
            rd = 16'd0;
         end else begin
            if (cyc_q.size() == 0 && p.run) build_cycle(p.ram);
            o = (cyc_q.size() != 0) ? cyc_q.pop_front() : 6'd0;
            rd = m_shadow[p.rda];
            if (p.we) m_shadow[p.addr] = p.data;
         end
         ev = {o, rd};
         if (elen > 0 && ev === cv) begin
            elen++;
         end else begin
            if (elen > 0) exp_q.push_back('{cv, elen});
            cv = ev;
            elen = 1;
         end
      end
      if (elen > 0) exp_q.push_back('{cv, elen});
   endtask

   // ---------------- driver / monitor ----------------
   task automatic apply(input plan_t p);
      rst_n = p.rst_n; isrun = p.run; isramsey = p.ram;
      cfg_we = p.we; cfg_addr = p.addr; cfg_data = p.data;
      rd_addr = p.rda;
   endtask

   task automatic check_seg(input logic [21:0] v, input int len,
                            input int idx);
      seg_t e;
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL seg%0d: got %h x%0d, want no further segment",
                  idx, v, len);
      end else begin
         e = exp_q.pop_front();
         if (e.v !== v || e.len != len)
            $display("FAIL seg%0d: got %h x%0d, want %h x%0d",
                     idx, v, len, e.v, e.len);
         else
            passed++;
      end
   endtask

   task automatic monitor(input int nclk);
      logic [21:0] cur, s;
      int len, seg;
      len = 0; seg = 0; cur = '0;
      for (int k = 1; k <= nclk; k++) begin
         @(negedge clk);
         s = {laser, mw, gate, sync, busy, cycle_done, rd_data};
         if (len == 0) begin
            cur = s; len = 1;
         end else if (s === cur) begin
            len++;
         end else begin
            check_seg(cur, len, seg);
            seg++;
            cur = s; len = 1;
         end
      end
      if (len > 0) check_seg(cur, len, seg);
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL tail: got 0 more segments, want %0d", exp_q.size());
   endtask

   task automatic driver(input int nclk);
      for (int n = 0; n < nclk; n++) begin
         apply(plan[n]);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int nclk, len;
      cur_ram = 1'b1;
      cur_rda = 3'd0;
      rst(3);
      idle(2);

      // Ramsey reference table, two back-to-back cycles
      tbl = '{16'd2, 16'd1, 16'd3, 16'd4, 16'($urandom_range(0, 9)),
              16'd5, 16'd2, 16'd1};
      load_tbl();
      hold(19 * P + 1);
      idle(50 * P);

      // Rabi, long MW
      cur_ram = 1'b0;
      tbl = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd7, 16'd1, 16'd1, 16'd1};
      load_tbl();
      hold(1);
      idle(30 * P);

      // TAU rewritten while a cycle is in its TAU segment
      cur_ram = 1'b1;
      tbl = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd1, 16'd1};
      load_tbl();
      hold(5 * P);
      cur_rda = 3'd3;
      wr(3'd3, 16'd10, 1'b1);
      hold(30 * P);
      idle(50 * P);

      // Zero GAP, gate longer than READ
      cur_ram = 1'($urandom_range(0, 1));
      tbl = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd4, 16'd9, 16'd1};
      load_tbl();
      hold(1);
      idle(30 * P);

      // Drop run while in PI2A
      cur_ram = 1'b1;
      tbl = '{16'd2, 16'd1, 16'd3, 16'd4, 16'd1, 16'd5, 16'd2, 16'd1};
      load_tbl();
      hold(3 * P + 2);
      idle(40 * P);

      // Reset while in READ, then read every address back
      hold(13 * P + 2);
      rst(1);
      for (int a = 0; a < 8; a++) begin
         cur_rda = 3'(a);
         idle(1);
      end
      idle(3);

      // Randomized sessions
      for (int s = 0; s < 30; s++) begin
         cur_rda = 3'($urandom_range(0, 7));
         repeat ($urandom_range(0, 4))
            wr(3'($urandom_range(0, 7)), 16'($urandom_range(0, 6)), 1'b0);
         cur_ram = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 80);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) cur_ram = ~cur_ram;
            if ($urandom_range(0, 11) == 0)
               wr(3'($urandom_range(0, 7)), 16'($urandom_range(0, 6)), 1'b1);
            else
               hold(1);
         end
         if ($urandom_range(0, 7) == 0) rst(1);
         idle($urandom_range(0, 60 * P));
      end
      idle(100 * P);

      run_model();
      nclk = plan.size();
      fork
         driver(nclk);
         monitor(nclk);
      join
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
